// File: rtl/ram_responder_if.sv
// RAM port bundle between a memory controller (master) and a RAM model (slave).
//   ramREN   : read request, held until ACCESS
//   ramWEN   : write request, held until ACCESS
//   ramaddr  : byte address
//   ramstore : write data
//   ramload  : read data (valid in ACCESS of a read)
//   ramstate : FREE=0, BUSY=1, ACCESS=2, ERROR=3
interface ram_responder_if;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_responder.sv
// Behavioural RAM with programmable access latency.
// A legal request shows BUSY for LAT cycles, then ACCESS for one cycle; a write
// commits at the end of the ACCESS cycle. Any change to the request while BUSY
// restarts the latency; an illegal request (read+write, misaligned or out of
// range address) shows ERROR and keeps no state.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset (clears the array too)
//   bus  : ram_responder_if.slave (ramREN/ramWEN/ramaddr/ramstore in,
//          ramload/ramstate out)
module ram_responder #(
    parameter int unsigned LAT    = 2,
    parameter int unsigned ADDR_W = 10
) (
    input  logic CLK,
    input  logic nRST,
    ram_responder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [3:0]  LAT_W = 4'(LAT);

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    if (LAT > 15) begin : g_bad_lat
        $error("ram_responder: LAT must be in 0..15");
    end
    if (ADDR_W < 1 || ADDR_W > 30) begin : g_bad_addr_w
        $error("ram_responder: ADDR_W must be in 1..30");
    end

    logic              active;
    logic [3:0]        cnt;
    logic              ren_q;
    logic              wen_q;
    logic [31:0]       addr_q;
    logic [31:0]       store_q;
    logic [31:0]       mem [DEPTH];

    logic              req;
    logic              illegal;
    logic              match;
    logic [3:0]        e;
    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;

    assign idx     = bus.ramaddr[ADDR_W+1:2];
    assign req     = bus.ramREN | bus.ramWEN;
    assign illegal = (bus.ramREN & bus.ramWEN)
                   | (bus.ramaddr[1:0] != 2'b00)
                   | ((bus.ramaddr >> (ADDR_W + 2)) != 32'd0);

    // The count only carries over while the request is held unchanged.
    assign match = active
                 & (bus.ramREN == ren_q)
                 & (bus.ramWEN == wen_q)
                 & (bus.ramaddr == addr_q)
                 & (bus.ramstore == store_q);
    assign e     = match ? cnt : 4'd0;

    always_comb begin
        state = BUSY;
        if (!req) begin
            state = FREE;
        end else if (illegal) begin
            state = ERROR;
        end else if (e == LAT_W) begin
            state = ACCESS;
        end
    end

    // Outputs are forced idle while reset is asserted.
    assign bus.ramstate = nRST ? state : FREE;
    assign bus.ramload  = (nRST && state == ACCESS && bus.ramREN) ? mem[idx] : 32'h0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            active  <= 1'b0;
            cnt     <= 4'd0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= 32'h0;
            store_q <= 32'h0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            unique case (state)
                BUSY: begin
                    active  <= 1'b1;
                    cnt     <= e + 4'd1;
                    ren_q   <= bus.ramREN;
                    wen_q   <= bus.ramWEN;
                    addr_q  <= bus.ramaddr;
                    store_q <= bus.ramstore;
                end
                ACCESS: begin
                    active <= 1'b0;
                    cnt    <= 4'd0;
                    if (bus.ramWEN) begin
                        mem[idx] <= bus.ramstore;
                    end
                end
                default: begin
                    active <= 1'b0;
                    cnt    <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: three instances (LAT=2, LAT=0, LAT=3)
// driven with hand-computed request sequences.
module tb_ram_responder;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic clk;
    logic nrst;
    logic nrst3;
    int   total;
    int   bad;

    ram_responder_if bus2 ();
    ram_responder_if bus0 ();
    ram_responder_if bus3 ();

    ram_responder #(.LAT(2), .ADDR_W(10)) u_lat2 (.CLK(clk), .nRST(nrst),  .bus(bus2));
    ram_responder #(.LAT(0), .ADDR_W(10)) u_lat0 (.CLK(clk), .nRST(nrst),  .bus(bus0));
    ram_responder #(.LAT(3), .ADDR_W(10)) u_lat3 (.CLK(clk), .nRST(nrst3), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic set2(input logic ren, input logic wen, input logic [31:0] a,
                        input logic [31:0] d);
        bus2.ramREN = ren; bus2.ramWEN = wen; bus2.ramaddr = a; bus2.ramstore = d;
    endtask

    task automatic set0(input logic ren, input logic wen, input logic [31:0] a,
                        input logic [31:0] d);
        bus0.ramREN = ren; bus0.ramWEN = wen; bus0.ramaddr = a; bus0.ramstore = d;
    endtask

    task automatic set3(input logic ren, input logic wen, input logic [31:0] a,
                        input logic [31:0] d);
        bus3.ramREN = ren; bus3.ramWEN = wen; bus3.ramaddr = a; bus3.ramstore = d;
    endtask

    // Current cycle: check state/load, then advance to the next drive point.
    task automatic cyc2(input string tag, input logic [1:0] st, input logic [31:0] ld);
        to_sample();
        check_eq({tag, "_st"}, 32'(bus2.ramstate), 32'(st));
        check_eq({tag, "_ld"}, bus2.ramload, ld);
        to_drive();
    endtask

    task automatic cyc3(input string tag, input logic [1:0] st, input logic [31:0] ld);
        to_sample();
        check_eq({tag, "_st"}, 32'(bus3.ramstate), 32'(st));
        check_eq({tag, "_ld"}, bus3.ramload, ld);
        to_drive();
    endtask

    task automatic cyc0(input string tag, input logic [1:0] st, input logic [31:0] ld);
        to_sample();
        check_eq({tag, "_st"}, 32'(bus0.ramstate), 32'(st));
        check_eq({tag, "_ld"}, bus0.ramload, ld);
        to_drive();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nrst  = 1'b0;
        nrst3 = 1'b0;
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        set3(1'b0, 1'b0, 32'h0, 32'h0);
        // Request held during reset: outputs must still read idle.
        set2(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        #2;
        check_eq("rst_st", 32'(bus2.ramstate), 32'(FREE));
        check_eq("rst_ld", bus2.ramload, 32'h0);
        to_drive();
        nrst  = 1'b1;
        nrst3 = 1'b1;

        // 1. write 0x10 with LAT=2
        cyc2("wr10_c0", BUSY, 32'h0);
        cyc2("wr10_c1", BUSY, 32'h0);
        cyc2("wr10_c2", ACCESS, 32'h0);

        // 2. read back 0x10, then read untouched 0x14
        set2(1'b1, 1'b0, 32'h10, 32'h0);
        cyc2("rd10_c0", BUSY, 32'h0);
        cyc2("rd10_c1", BUSY, 32'h0);
        cyc2("rd10_c2", ACCESS, 32'hDEADBEEF);
        set2(1'b1, 1'b0, 32'h14, 32'h0);
        cyc2("rd14_c0", BUSY, 32'h0);
        cyc2("rd14_c1", BUSY, 32'h0);
        cyc2("rd14_c2", ACCESS, 32'h0);

        // 3a. read 0x20 preempted by write 0x40: full latency paid again
        set2(1'b1, 1'b0, 32'h20, 32'h0);
        cyc2("pre_rd", BUSY, 32'h0);
        set2(1'b0, 1'b1, 32'h40, 32'h11111111);
        cyc2("pre_wr0", BUSY, 32'h0);
        cyc2("pre_wr1", BUSY, 32'h0);
        cyc2("pre_wr2", ACCESS, 32'h0);
        // 3b. write 0x40 dropped after one BUSY cycle
        set2(1'b0, 1'b1, 32'h40, 32'h22222222);
        cyc2("drop_busy", BUSY, 32'h0);
        set2(1'b0, 1'b0, 32'h40, 32'h22222222);
        cyc2("drop_free", FREE, 32'h0);
        set2(1'b1, 1'b0, 32'h40, 32'h0);
        cyc2("rd40_c0", BUSY, 32'h0);
        cyc2("rd40_c1", BUSY, 32'h0);
        cyc2("rd40_c2", ACCESS, 32'h11111111);

        // 4. illegal requests: ERROR held, no array change, correction is e=0
        set2(1'b1, 1'b1, 32'h40, 32'h33333333);
        cyc2("err_rw0", ERROR, 32'h0);
        cyc2("err_rw1", ERROR, 32'h0);
        set2(1'b1, 1'b0, 32'h40, 32'h0);
        cyc2("fix_rw0", BUSY, 32'h0);
        cyc2("fix_rw1", BUSY, 32'h0);
        cyc2("fix_rw2", ACCESS, 32'h11111111);
        set2(1'b0, 1'b1, 32'h3, 32'h44444444);
        cyc2("err_mis0", ERROR, 32'h0);
        cyc2("err_mis1", ERROR, 32'h0);
        set2(1'b1, 1'b0, 32'h0, 32'h0);
        cyc2("fix_mis0", BUSY, 32'h0);
        cyc2("fix_mis1", BUSY, 32'h0);
        cyc2("fix_mis2", ACCESS, 32'h0);
        set2(1'b0, 1'b1, 32'h1000, 32'h55555555);
        cyc2("err_rng0", ERROR, 32'h0);
        cyc2("err_rng1", ERROR, 32'h0);
        set2(1'b1, 1'b0, 32'h0, 32'h0);
        cyc2("fix_rng0", BUSY, 32'h0);
        cyc2("fix_rng1", BUSY, 32'h0);
        cyc2("fix_rng2", ACCESS, 32'h0);
        set2(1'b0, 1'b0, 32'h0, 32'h0);
        cyc2("idle2", FREE, 32'h0);

        // 5. LAT=0: ACCESS in the first request cycle
        set0(1'b0, 1'b1, 32'h8, 32'h12345678);
        cyc0("l0_wr", ACCESS, 32'h0);
        set0(1'b1, 1'b0, 32'h8, 32'h0);
        cyc0("l0_rd0", ACCESS, 32'h12345678);
        cyc0("l0_rd1", ACCESS, 32'h12345678);
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        cyc0("l0_idle", FREE, 32'h0);

        // 6. LAT=3 write, reset pulsed during the second BUSY cycle
        set3(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5);
        cyc3("l3_c0", BUSY, 32'h0);
        to_sample();
        check_eq("l3_c1_st", 32'(bus3.ramstate), 32'(BUSY));
        #1;
        nrst3 = 1'b0;
        #1;
        check_eq("l3_rst_st", 32'(bus3.ramstate), 32'(FREE));
        check_eq("l3_rst_ld", bus3.ramload, 32'h0);
        to_drive();
        check_eq("l3_rst_st2", 32'(bus3.ramstate), 32'(FREE));
        nrst3 = 1'b1;
        #1;
        check_eq("l3_mem0", u_lat3.mem[0], 32'h0);
        cyc3("l3_r0", BUSY, 32'h0);
        cyc3("l3_r1", BUSY, 32'h0);
        cyc3("l3_r2", BUSY, 32'h0);
        cyc3("l3_r3", ACCESS, 32'h0);
        set3(1'b1, 1'b0, 32'h0, 32'h0);
        cyc3("l3_rd0", BUSY, 32'h0);
        cyc3("l3_rd1", BUSY, 32'h0);
        cyc3("l3_rd2", BUSY, 32'h0);
        cyc3("l3_rd3", ACCESS, 32'hA5A5A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
Behavioural RAM responder at the far end of the memory_control RAM port (ramREN/ramWEN/ramaddr/ramstore in; ramload/ramstate out). It holds a word array, applies a programmable access latency, and reports progress through the cpu_types_pkg ramstate_t encoding: FREE, BUSY, ACCESS, ERROR. It stands in for the RAM in single-cycle, pipelined and cache benches, so arbitration and wait logic see a realistic, latency-bearing target.

Parameters:
LAT, 2, cycles of BUSY before the ACCESS cycle; 0 gives ACCESS in the first request cycle; legal range 0..15.
ADDR_W, 10, word-index width; DEPTH = 2^ADDR_W words.

Ports:
CLK  input  1  clock, rising edge.
nRST  input  1  asynchronous active-low reset.
ramREN  input  1  read request, held by the initiator until ACCESS.
ramWEN  input  1  write request, held by the initiator until ACCESS.
ramaddr  input  32  byte address of the access.
ramstore  input  32  write data.
ramload  output  32  read data.
ramstate  output  2  ramstate_t: FREE, BUSY, ACCESS or ERROR.

Behaviour:
- Word index = ramaddr[ADDR_W+1:2].
- Request present: req = ramREN | ramWEN.
- Illegal request, any of:
  - ramREN & ramWEN;
  - ramaddr[1:0] != 0;
  - ramaddr[31:ADDR_W+2] != 0.
- Registers:
  - active (1 bit);
  - cnt (4 bit);
  - latched copy of ramREN, ramWEN, ramaddr, ramstore;
  - mem[DEPTH] of 32 bit.
- match = active & (all four inputs equal to the latched copy).
- Elapsed count e = match ? cnt : 0.
- ramstate is combinational from inputs and registers:
  - no req -> FREE;
  - illegal -> ERROR;
  - e == LAT -> ACCESS;
  - otherwise BUSY.
- Sequential update, on the clock edge:
  - FREE or ERROR: active <= 0, cnt <= 0; the array is untouched.
  - BUSY: active <= 1, latch inputs, cnt <= e+1.
  - ACCESS: active <= 0, cnt <= 0. If ramWEN, mem[index] <= ramstore at this edge.
- Latency: a request first seen in cycle t gives BUSY in cycles t..t+LAT-1 and ACCESS in cycle t+LAT. The write commits at the end of t+LAT.
- Back-to-back requests:
  - A request still held in cycle t+LAT+1 is a new request and restarts at BUSY (or ACCESS when LAT=0).
  - With LAT=0, a held request is ACCESS every cycle; a held write rewrites every cycle.
- Request change during BUSY: any change to ramaddr, ramstore, ramREN or ramWEN restarts the count. The changed cycle counts as e=0 of the new request, so the full LAT is paid again. Used for the data-over-instruction preemption in memory_control.
- Request drop during BUSY: the cycle is FREE, the count is discarded, and no write occurs.
- ramload:
  - In ACCESS with ramREN: combinational mem[index].
  - Otherwise 32'h0, including BUSY, ERROR, writes and FREE.
- ERROR holds no state: the same illegal request shows ERROR every cycle until it is corrected. The correction cycle is e=0.
- Reset (nRST low, asynchronous):
  - active=0, cnt=0, latched fields=0, all mem words=0;
  - ramstate forced FREE, ramload forced 0 while nRST is low.
  - A reset mid-BUSY abandons the request, and a pending write is never committed.
  - After release, a held request is treated as new (BUSY at e=0).
- Counter width: cnt never exceeds LAT, so there is no wrap. LAT > 15 is illegal, flagged by an elaboration-time assertion.

Test Plan:
1. LAT=2, after reset, write ramaddr=0x10, ramstore=0xDEADBEEF held -> BUSY, BUSY, ACCESS on cycles 0..2; mem[4]=0xDEADBEEF after cycle 2; ramload=0 throughout.
2. Read of the same address held -> BUSY, BUSY, then ACCESS with ramload=0xDEADBEEF; ramload=0 on the BUSY cycles. Read 0x14 -> ACCESS with ramload=0.
3. Preemption:
   - read 0x20 for 1 cycle, then switch to write 0x40 -> BUSY restarts; ACCESS in the 3rd cycle after the switch.
   - write 0x40 then dropped after 1 BUSY cycle -> FREE; mem[16] unchanged.
4. Errors:
   - ramREN=ramWEN=1 -> ERROR;
   - ramaddr=0x3 -> ERROR;
   - ramaddr=0x1000 with ADDR_W=10 -> ERROR;
   - in all three cases no array change, and correcting the request gives BUSY (e=0).
5. LAT=0:
   - write 0x8 = 0x12345678 -> ACCESS in the same cycle;
   - read next cycle -> ACCESS with ramload=0x12345678.
6. LAT=3, write 0x0 = 0xA5A5A5A5, nRST pulsed low during the 2nd BUSY cycle:
   - ramstate=FREE while reset is low;
   - after release, mem[0]=0 and the held write restarts with 3 BUSY cycles before ACCESS.
